pll_map_top: RTL and testbench

PLL_MAP_TOP -- requirements
Module: pll_map_top

---
 rtl/pll_map_top.sv | 168 ++++++++++++++++
 tb/tb_pll_map_top.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_map_top.sv
// SPI-configured clock generator: a 512-bit SPI frame sets the divide ratio and enable,
// and registered dividers produce clkpll (/2*ratio), clkpll0 (/2) and clkpll1 (/4).
module pll_map_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mosi,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       start,
  output logic       tx_finish,
  output logic       lock,
  output logic       clkpll,
  output logic       clkpll0,
  output logic       clkpll1,
  output logic [1:0] view_dig_out,
  output logic [2:0] odfx_fscan_sdo,
  output logic [1:0] viewanabus,
  output logic       idvdisable_bo,
  output logic       idvfreqao,
  output logic       idvfreqbo,
  output logic       idvpulseo,
  output logic       idvtclko,
  output logic       idvtctrlo,
  output logic       idvtdo,
  output logic       idvtreso,
  output logic       tdo
);

  localparam logic [9:0] FRAME_BITS    = 10'd512;
  localparam logic [9:0] DEFAULT_RATIO = 10'd6;

  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0]   sclk_sync_q, sclk_sync_d;
  logic [2:0]   ss_sync_q, ss_sync_d;
  logic [1:0]   mosi_sync_q, mosi_sync_d;

  logic [511:0] shift_q, shift_d;
  logic [9:0]   bit_cnt_q, bit_cnt_d;
  logic         tx_finish_q, tx_finish_d;
  logic [9:0]   ratio_q, ratio_d;
  logic         pllen_q, pllen_d;
  logic         read_flag_q, read_flag_d;
  logic         valid_q, valid_d;
  logic         lock_en_q, lock_en_d;
  logic [9:0]   div_cnt_q, div_cnt_d;
  logic         clkpll_q, clkpll_d;
  logic         clkpll0_q, clkpll0_d;
  logic         clkpll1_q, clkpll1_d;

  logic         sclk_rise, ss_fall, ss_rise, cnt_clear, cfg_load;
  logic [9:0]   ratio_eff;
  logic         unused_frame_msb;

  assign unused_frame_msb = shift_q[511];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    ss_sync_d   = {ss_sync_q[1:0], ss_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ratio_d     = ratio_q;
    pllen_d     = pllen_q;
    read_flag_d = read_flag_q;
    div_cnt_d   = div_cnt_q + 10'd1;
    clkpll_d    = clkpll_q;
    clkpll0_d   = clkpll0_q;
    clkpll1_d   = clkpll1_q;
    lock_en_d   = 1'b1;

    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    cnt_clear = start | ss_fall;

    // A clear in the same cycle as an sclk edge drops that edge entirely.
    if (cnt_clear) begin
      bit_cnt_d = '0;
    end else if (!ss_sync_q[1] && sclk_rise) begin
      shift_d = {shift_q[510:0], mosi_sync_q[1]};
      if (bit_cnt_q != FRAME_BITS) bit_cnt_d = bit_cnt_q + 10'd1;
    end

    tx_finish_d = ss_rise && (bit_cnt_q == FRAME_BITS);

    // The frame stays put in shift_q while ss_n is high, so decode it in the tx_finish cycle.
    cfg_load = tx_finish_q & shift_q[1];
    if (tx_finish_q) read_flag_d = shift_q[0];
    if (cfg_load) begin
      ratio_d = shift_q[12:3];
      pllen_d = shift_q[2];
    end
    valid_d = cfg_load;

    ratio_eff = (ratio_q == 10'd0) ? 10'd1 : ratio_q;

    if (cfg_load) begin
      div_cnt_d = '0;
      clkpll_d  = 1'b0;
      clkpll0_d = 1'b0;
      clkpll1_d = 1'b0;
    end else if (div_cnt_q == ratio_eff - 10'd1) begin
      div_cnt_d = '0;
      clkpll_d  = ~clkpll_q;
      if (!clkpll_q) begin
        clkpll0_d = ~clkpll0_q;
        if (!clkpll0_q) clkpll1_d = ~clkpll1_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_finish_q <= 1'b0;
      ratio_q     <= DEFAULT_RATIO;
      pllen_q     <= 1'b0;
      read_flag_q <= 1'b0;
      valid_q     <= 1'b0;
      lock_en_q   <= 1'b0;
      div_cnt_q   <= '0;
      clkpll_q    <= 1'b0;
      clkpll0_q   <= 1'b0;
      clkpll1_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_finish_q <= tx_finish_d;
      ratio_q     <= ratio_d;
      pllen_q     <= pllen_d;
      read_flag_q <= read_flag_d;
      valid_q     <= valid_d;
      lock_en_q   <= lock_en_d;
      div_cnt_q   <= div_cnt_d;
      clkpll_q    <= clkpll_d;
      clkpll0_q   <= clkpll0_d;
      clkpll1_q   <= clkpll1_d;
    end
  end

  assign tx_finish      = tx_finish_q;
  assign lock           = lock_en_q & ~valid_q;
  assign clkpll         = clkpll_q;
  assign clkpll0        = clkpll0_q;
  assign clkpll1        = clkpll1_q;
  assign view_dig_out   = {read_flag_q, pllen_q};
  assign odfx_fscan_sdo = 3'b000;
  assign viewanabus     = 2'b00;
  assign idvdisable_bo  = 1'b0;
  assign idvfreqao      = 1'b0;
  assign idvfreqbo      = 1'b0;
  assign idvpulseo      = 1'b0;
  assign idvtclko       = 1'b0;
  assign idvtctrlo      = 1'b0;
  assign idvtdo         = 1'b0;
  assign idvtreso       = 1'b0;
  assign tdo            = 1'b0;

endmodule

// File: tb/tb_pll_map_top.sv
// Directed bench for pll_map_top: SPI frames with hand-computed ratios, clock periods,
// lock behaviour, aborted frames, start clearing and mid-frame reset.
module tb_pll_map_top;

  logic       clk = 1'b0;
  logic       rst_n, mosi, sclk, ss_n, start;
  logic       tx_finish, lock, clkpll, clkpll0, clkpll1;
  logic [1:0] view_dig_out, viewanabus;
  logic [2:0] odfx_fscan_sdo;
  logic       idvdisable_bo, idvfreqao, idvfreqbo, idvpulseo, idvtclko;
  logic       idvtctrlo, idvtdo, idvtreso, tdo;

  int checks = 0;
  int errors = 0;

  int cyc = 0, tx_cnt = 0, tx_cyc = -1, lock_low_cnt = 0, lock_cyc = -1;
  logic [2:0] clks_at_lock_low = 3'b000;

  always #5 clk = ~clk;

  pll_map_top dut (
    .clk(clk), .rst_n(rst_n), .mosi(mosi), .sclk(sclk), .ss_n(ss_n), .start(start),
    .tx_finish(tx_finish), .lock(lock), .clkpll(clkpll), .clkpll0(clkpll0), .clkpll1(clkpll1),
    .view_dig_out(view_dig_out), .odfx_fscan_sdo(odfx_fscan_sdo), .viewanabus(viewanabus),
    .idvdisable_bo(idvdisable_bo), .idvfreqao(idvfreqao), .idvfreqbo(idvfreqbo),
    .idvpulseo(idvpulseo), .idvtclko(idvtclko), .idvtctrlo(idvtctrlo), .idvtdo(idvtdo),
    .idvtreso(idvtreso), .tdo(tdo)
  );

  // Event monitor, sampled on the falling edge away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_finish) begin
      tx_cnt++;
      tx_cyc = cyc;
    end
    if (!lock && !rst_n) begin
      lock_low_cnt++;
      lock_cyc = cyc;
      clks_at_lock_low = {clkpll, clkpll0, clkpll1};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] make_frame(input logic rd, input logic wr, input logic en,
                                              input logic [9:0] ratio);
    logic [511:0] f;
    f = {16{32'hDEADBEEF}};
    f[12:0] = {ratio, en, wr, rd};
    return f;
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return clkpll;
      1:       return clkpll0;
      default: return clkpll1;
    endcase
  endfunction

  // Rising-edge-to-rising-edge period in clk cycles; -1 when the bound expires.
  task automatic measure(input int sel, output int per);
    logic prev, cur;
    int t0;
    per  = -1;
    t0   = -1;
    prev = pick(sel);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cur = pick(sel);
      if (cur && !prev) begin
        if (t0 < 0) t0 = n;
        else begin
          per = n - t0;
          break;
        end
      end
      prev = cur;
    end
  endtask

  task automatic send_bits(input logic [511:0] f, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = f[511 - (first + i)];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [511:0] f, input int nbits);
    tx_cnt       = 0;
    lock_low_cnt = 0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(f, 0, nbits);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  int per;

  initial begin
    rst_n = 1'b1; mosi = 1'b0; sclk = 1'b0; ss_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_lock", lock, 0);
    check("rst_tx_finish", tx_finish, 0);
    check("rst_clocks", {clkpll, clkpll0, clkpll1}, 0);
    check("rst_view", view_dig_out, 0);
    check("const_debug", {odfx_fscan_sdo, viewanabus, idvdisable_bo, idvfreqao, idvfreqbo,
                          idvpulseo, idvtclko, idvtctrlo, idvtdo, idvtreso, tdo}, 0);

    rst_n = 1'b0;
    @(negedge clk);
    check("lock_after_release", lock, 1);
    measure(0, per); check("default_clkpll_period", per, 12);
    measure(1, per); check("default_clkpll0_period", per, 24);
    measure(2, per); check("default_clkpll1_period", per, 48);

    // Write ratio 11, pllen 0.
    send_frame(make_frame(1'b0, 1'b1, 1'b0, 10'd11), 512);
    check("wr11_tx_pulses", tx_cnt, 1);
    check("wr11_lock_low_cycles", lock_low_cnt, 1);
    check("wr11_lock_low_after_tx", lock_cyc - tx_cyc, 1);
    check("wr11_clocks_low_in_valid", clks_at_lock_low, 0);
    check("wr11_view", view_dig_out, 2'b00);
    measure(0, per); check("wr11_clkpll_period", per, 22);

    // Write bit clear: configuration must not change.
    send_frame(make_frame(1'b0, 1'b0, 1'b1, 10'd3), 512);
    check("nowr_tx_pulses", tx_cnt, 1);
    check("nowr_lock_low_cycles", lock_low_cnt, 0);
    check("nowr_view", view_dig_out, 2'b00);
    measure(0, per); check("nowr_clkpll_period", per, 22);

    // Short frame is discarded.
    send_frame(make_frame(1'b1, 1'b1, 1'b1, 10'd2), 300);
    check("short_tx_pulses", tx_cnt, 0);
    check("short_view", view_dig_out, 2'b00);
    measure(0, per); check("short_clkpll_period", per, 22);

    send_frame(make_frame(1'b0, 1'b1, 1'b1, 10'd5), 512);
    check("wr5_tx_pulses", tx_cnt, 1);
    check("wr5_view", view_dig_out, 2'b01);
    measure(0, per); check("wr5_clkpll_period", per, 10);

    // start after 400 bits leaves only 112 counted bits: frame rejected.
    tx_cnt = 0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(make_frame(1'b1, 1'b1, 1'b0, 10'd7), 0, 400);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bits(make_frame(1'b1, 1'b1, 1'b0, 10'd7), 400, 112);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    check("start_clear_tx_pulses", tx_cnt, 0);
    check("start_clear_view", view_dig_out, 2'b01);

    // Ratio 0 behaves as ratio 1.
    send_frame(make_frame(1'b0, 1'b1, 1'b0, 10'd0), 512);
    check("wr0_tx_pulses", tx_cnt, 1);
    measure(0, per); check("wr0_clkpll_period", per, 2);
    measure(1, per); check("wr0_clkpll0_period", per, 4);

    send_frame(make_frame(1'b1, 1'b1, 1'b1, 10'd4), 512);
    check("rd_wr_en_view", view_dig_out, 2'b11);
    measure(0, per); check("wr4_clkpll_period", per, 8);

    // Reset in the middle of a frame.
    tx_cnt = 0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(make_frame(1'b1, 1'b1, 1'b1, 10'd9), 0, 100);
    rst_n = 1'b1;
    ss_n  = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_lock", lock, 0);
    check("midrst_clocks", {clkpll, clkpll0, clkpll1}, 0);
    check("midrst_view", view_dig_out, 2'b00);
    check("midrst_tx_finish", tx_finish, 0);
    rst_n = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_tx_pulses", tx_cnt, 0);
    check("midrst_lock_after", lock, 1);
    measure(0, per); check("midrst_clkpll_period", per, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
